// File: rtl/mem_stage.sv
// MEM stage of the 16-bit core: EX/MEM and MEM/WB pipeline registers, the SZCV flag
// register, and a req/ack data-memory access FSM with a timeout abort.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_ex,
  input  logic [15:0] ALUres_ex,
  input  logic [15:0] rd1_ex2,
  input  logic        S_ex,
  input  logic        Z_ex,
  input  logic        C_ex,
  input  logic        V_ex,
  input  logic        flagwrite_ex,
  input  logic        memread_ex,
  input  logic        memwrite_ex,
  input  logic        regwrite_ex,
  input  logic [2:0]  wreg_ex,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdat,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdat,
  output logic        stall_mem,
  output logic [15:0] regwrite_dat_mem,
  output logic        regwrite_mem,
  output logic [2:0]  wreg_mem,
  output logic        wb_we,
  output logic [2:0]  wb_reg,
  output logic [15:0] wb_dat,
  output logic [3:0]  flags,
  output logic        bus_err
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic        valid_mem_q;
  logic [15:0] alures_mem_q;
  logic [15:0] rd1_mem_q;
  logic        memread_mem_q;
  logic        memwrite_mem_q;
  logic        regwrite_mem_q;
  logic [2:0]  wreg_mem_q;
  logic [3:0]  flags_q;
  logic        bus_err_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        aborted_q;
  logic        wb_we_q;
  logic [2:0]  wb_reg_q;
  logic [15:0] wb_dat_q;

  logic        in_access;
  logic        mem_op_ex;
  logic        abort_now;

  assign in_access = (state_q == ACCESS);
  assign mem_op_ex = valid_ex && (memread_ex || memwrite_ex);
  assign cnt_d     = cnt_q + 16'd1;

  // An ack on the limit cycle wins: abort only fires when the ack is absent.
  assign abort_now = in_access && !dmem_ack && (cnt_q == CNT_LAST);
  assign stall_mem = in_access && !dmem_ack;

  // NOTE: every register here is a plain flop (no memory array), so all of them take
  // the reset value; sequential state is assigned with <= only to avoid update races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      valid_mem_q    <= 1'b0;
      alures_mem_q   <= '0;
      rd1_mem_q      <= '0;
      memread_mem_q  <= 1'b0;
      memwrite_mem_q <= 1'b0;
      regwrite_mem_q <= 1'b0;
      wreg_mem_q     <= '0;
      flags_q        <= '0;
      bus_err_q      <= 1'b0;
      cnt_q          <= '0;
      aborted_q      <= 1'b0;
      wb_we_q        <= 1'b0;
      wb_reg_q       <= '0;
      wb_dat_q       <= '0;
    end else if (!stall_mem) begin
      valid_mem_q    <= valid_ex;
      alures_mem_q   <= ALUres_ex;
      rd1_mem_q      <= rd1_ex2;
      memread_mem_q  <= memread_ex  && valid_ex;
      memwrite_mem_q <= memwrite_ex && valid_ex;
      regwrite_mem_q <= regwrite_ex && valid_ex;
      wreg_mem_q     <= wreg_ex;
      if (valid_ex && flagwrite_ex) begin
        flags_q <= {S_ex, Z_ex, C_ex, V_ex};
      end
      wb_we_q   <= regwrite_mem_q && valid_mem_q && !aborted_q;
      wb_reg_q  <= wreg_mem_q;
      wb_dat_q  <= memread_mem_q ? dmem_rdat : alures_mem_q;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= mem_op_ex ? ACCESS : IDLE;
    end else begin
      // Stalled in ACCESS: hold EX/MEM and flags, push a bubble into writeback.
      wb_we_q <= 1'b0;
      if (abort_now) begin
        state_q   <= IDLE;
        bus_err_q <= 1'b1;
        aborted_q <= 1'b1;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign dmem_req  = in_access && !reset;
  assign dmem_we   = dmem_req && memwrite_mem_q;
  assign dmem_addr = alures_mem_q;
  assign dmem_wdat = rd1_mem_q;

  // Load data is never forwarded; the hazard unit covers load-use.
  assign regwrite_dat_mem = alures_mem_q;
  assign regwrite_mem     = regwrite_mem_q && valid_mem_q && !memread_mem_q;
  assign wreg_mem         = wreg_mem_q;

  assign wb_we   = wb_we_q;
  assign wb_reg  = wb_reg_q;
  assign wb_dat  = wb_dat_q;
  assign flags   = flags_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks and completed memory accesses are
// queued at issue time and popped by a monitor when the DUT presents them.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        valid_ex;
  logic [15:0] ALUres_ex;
  logic [15:0] rd1_ex2;
  logic        S_ex, Z_ex, C_ex, V_ex;
  logic        flagwrite_ex;
  logic        memread_ex;
  logic        memwrite_ex;
  logic        regwrite_ex;
  logic [2:0]  wreg_ex;
  logic        dmem_ack;
  logic [15:0] dmem_rdat;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdat;
  logic        stall_mem;
  logic [15:0] regwrite_dat_mem;
  logic        regwrite_mem;
  logic [2:0]  wreg_mem;
  logic        wb_we;
  logic [2:0]  wb_reg;
  logic [15:0] wb_dat;
  logic [3:0]  flags;
  logic        bus_err;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] dat;
  } wb_exp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdat;
  } mem_exp_t;

  wb_exp_t  exp_wb[$];
  mem_exp_t exp_mem[$];

  int checks   = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_ex         (valid_ex),
    .ALUres_ex        (ALUres_ex),
    .rd1_ex2          (rd1_ex2),
    .S_ex             (S_ex),
    .Z_ex             (Z_ex),
    .C_ex             (C_ex),
    .V_ex             (V_ex),
    .flagwrite_ex     (flagwrite_ex),
    .memread_ex       (memread_ex),
    .memwrite_ex      (memwrite_ex),
    .regwrite_ex      (regwrite_ex),
    .wreg_ex          (wreg_ex),
    .dmem_ack         (dmem_ack),
    .dmem_rdat        (dmem_rdat),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdat        (dmem_wdat),
    .stall_mem        (stall_mem),
    .regwrite_dat_mem (regwrite_dat_mem),
    .regwrite_mem     (regwrite_mem),
    .wreg_mem         (wreg_mem),
    .wb_we            (wb_we),
    .wb_reg           (wb_reg),
    .wb_dat           (wb_dat),
    .flags            (flags),
    .bus_err          (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive_ex(input logic v, input logic rw, input logic [2:0] wr,
                          input logic [15:0] res, input logic [15:0] rd1,
                          input logic fw, input logic [3:0] szcv,
                          input logic mr, input logic mw);
    valid_ex     = v;
    regwrite_ex  = rw;
    wreg_ex      = wr;
    ALUres_ex    = res;
    rd1_ex2      = rd1;
    flagwrite_ex = fw;
    {S_ex, Z_ex, C_ex, V_ex} = szcv;
    memread_ex   = mr;
    memwrite_ex  = mw;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  // Monitor: writebacks and acknowledged accesses are matched in order against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_we) begin
        if (exp_wb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected: got wb_reg=%0d wb_dat=0x%0h with nothing expected at %0t",
                   wb_reg, wb_dat, $time);
        end else begin
          wb_exp_t e;
          e = exp_wb.pop_front();
          check("wb_reg", 32'(wb_reg), 32'(e.rd));
          check("wb_dat", 32'(wb_dat), 32'(e.dat));
        end
      end
      if (dmem_req && dmem_ack) begin
        if (exp_mem.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_unexpected: got access addr=0x%0h with nothing expected at %0t",
                   dmem_addr, $time);
        end else begin
          mem_exp_t m;
          m = exp_mem.pop_front();
          check("mem_we",   32'(dmem_we),   32'(m.we));
          check("mem_addr", 32'(dmem_addr), 32'(m.addr));
          check("mem_wdat", 32'(dmem_wdat), 32'(m.wdat));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    dmem_ack  = 1'b0;
    dmem_rdat = 16'h0000;
    idle_ex();
    repeat (2) @(posedge clk);
    #1;
    at_neg();
    check("rst_req",     32'(dmem_req),  32'd0);
    check("rst_stall",   32'(stall_mem), 32'd0);
    check("rst_wb_we",   32'(wb_we),     32'd0);
    check("rst_wb_reg",  32'(wb_reg),    32'd0);
    check("rst_wb_dat",  32'(wb_dat),    32'd0);
    check("rst_flags",   32'(flags),     32'd0);
    check("rst_bus_err", 32'(bus_err),   32'd0);
    check("rst_fwd_we",  32'(regwrite_mem), 32'd0);
    tick();
    reset = 1'b0;

    // ALU op with flag update
    drive_ex(1'b1, 1'b1, 3'd3, 16'h1234, 16'h0000, 1'b1, 4'b1000, 1'b0, 1'b0);
    exp_wb.push_back('{rd: 3'd3, dat: 16'h1234});
    tick();
    idle_ex();
    at_neg();
    check("alu_fwd_dat", 32'(regwrite_dat_mem), 32'h1234);
    check("alu_fwd_reg", 32'(wreg_mem),         32'd3);
    check("alu_fwd_we",  32'(regwrite_mem),     32'd1);
    check("alu_flags",   32'(flags),            32'h8);
    check("alu_req",     32'(dmem_req),         32'd0);
    tick();

    // ALU op without flag update: flags hold
    drive_ex(1'b1, 1'b1, 3'd5, 16'hA5A5, 16'h0000, 1'b0, 4'b0111, 1'b0, 1'b0);
    exp_wb.push_back('{rd: 3'd5, dat: 16'hA5A5});
    tick();
    idle_ex();
    at_neg();
    check("alu2_flags_hold", 32'(flags), 32'h8);
    repeat (2) tick();

    // Load, ack on the 3rd ACCESS cycle; junk on EX during the stall is not captured
    drive_ex(1'b1, 1'b1, 3'd2, 16'h0040, 16'h7777, 1'b0, 4'b0000, 1'b1, 1'b0);
    exp_wb.push_back('{rd: 3'd2, dat: 16'hBEEF});
    exp_mem.push_back('{we: 1'b0, addr: 16'h0040, wdat: 16'h7777});
    tick();
    drive_ex(1'b1, 1'b1, 3'd7, 16'hDEAD, 16'h0000, 1'b1, 4'b1111, 1'b0, 1'b0);
    at_neg();
    check("ld_c1_req",    32'(dmem_req),  32'd1);
    check("ld_c1_addr",   32'(dmem_addr), 32'h0040);
    check("ld_c1_we",     32'(dmem_we),   32'd0);
    check("ld_c1_stall",  32'(stall_mem), 32'd1);
    check("ld_c1_fwd_we", 32'(regwrite_mem), 32'd0);
    tick();
    at_neg();
    check("ld_c2_req",   32'(dmem_req),  32'd1);
    check("ld_c2_addr",  32'(dmem_addr), 32'h0040);
    check("ld_c2_stall", 32'(stall_mem), 32'd1);
    check("ld_c2_flags", 32'(flags),     32'h8);
    tick();
    dmem_ack  = 1'b1;
    dmem_rdat = 16'hBEEF;
    drive_ex(1'b1, 1'b1, 3'd4, 16'h5555, 16'h0000, 1'b1, 4'b0100, 1'b0, 1'b0);
    exp_wb.push_back('{rd: 3'd4, dat: 16'h5555});
    at_neg();
    check("ld_c3_req",   32'(dmem_req),  32'd1);
    check("ld_c3_stall", 32'(stall_mem), 32'd0);
    tick();
    dmem_ack  = 1'b0;
    dmem_rdat = 16'h0000;
    idle_ex();
    at_neg();
    check("ld_after_flags",   32'(flags),            32'h4);
    check("ld_after_fwd_dat", 32'(regwrite_dat_mem), 32'h5555);
    check("ld_after_fwd_reg", 32'(wreg_mem),         32'd4);
    check("ld_after_req",     32'(dmem_req),         32'd0);
    repeat (2) tick();

    // Two back-to-back zero-wait stores
    drive_ex(1'b1, 1'b0, 3'd0, 16'h0010, 16'h00FF, 1'b0, 4'b0000, 1'b0, 1'b1);
    exp_mem.push_back('{we: 1'b1, addr: 16'h0010, wdat: 16'h00FF});
    tick();
    dmem_ack = 1'b1;
    drive_ex(1'b1, 1'b0, 3'd0, 16'h0011, 16'h0100, 1'b0, 4'b0000, 1'b0, 1'b1);
    exp_mem.push_back('{we: 1'b1, addr: 16'h0011, wdat: 16'h0100});
    at_neg();
    check("st1_we",    32'(dmem_we),   32'd1);
    check("st1_wdat",  32'(dmem_wdat), 32'h00FF);
    check("st1_stall", 32'(stall_mem), 32'd0);
    tick();
    idle_ex();
    at_neg();
    check("st2_req",   32'(dmem_req),  32'd1);
    check("st2_addr",  32'(dmem_addr), 32'h0011);
    check("st2_stall", 32'(stall_mem), 32'd0);
    tick();
    dmem_ack = 1'b0;
    at_neg();
    check("st_done_req", 32'(dmem_req), 32'd0);
    check("st_done_we",  32'(dmem_we),  32'd0);
    tick();

    // Invalid EX slot carrying flagwrite/memread/regwrite has no effect
    drive_ex(1'b0, 1'b1, 3'd6, 16'h0099, 16'h0000, 1'b1, 4'b0011, 1'b1, 1'b0);
    tick();
    idle_ex();
    at_neg();
    check("inv_flags",  32'(flags),        32'h4);
    check("inv_req",    32'(dmem_req),     32'd0);
    check("inv_fwd_we", 32'(regwrite_mem), 32'd0);
    repeat (2) tick();

    // Load that is never acknowledged: aborts after 4 request cycles
    drive_ex(1'b1, 1'b1, 3'd6, 16'h0080, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    idle_ex();
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check($sformatf("to_req_c%0d", i),   32'(dmem_req),  32'd1);
      check($sformatf("to_stall_c%0d", i), 32'(stall_mem), 32'd1);
      check($sformatf("to_err_c%0d", i),   32'(bus_err),   32'd0);
      tick();
    end
    at_neg();
    check("to_after_req",   32'(dmem_req),  32'd0);
    check("to_after_stall", 32'(stall_mem), 32'd0);
    check("to_after_err",   32'(bus_err),   32'd1);
    drive_ex(1'b1, 1'b1, 3'd1, 16'h0101, 16'h0000, 1'b1, 4'b0010, 1'b0, 1'b0);
    exp_wb.push_back('{rd: 3'd1, dat: 16'h0101});
    tick();
    idle_ex();
    at_neg();
    check("resume_fwd_reg", 32'(wreg_mem),     32'd1);
    check("resume_fwd_we",  32'(regwrite_mem), 32'd1);
    check("resume_flags",   32'(flags),        32'h2);
    repeat (2) tick();
    at_neg();
    check("err_sticky", 32'(bus_err), 32'd1);
    tick();

    // Reset asserted in the 2nd ACCESS cycle
    drive_ex(1'b1, 1'b1, 3'd3, 16'h0200, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    idle_ex();
    at_neg();
    check("mr_c1_req", 32'(dmem_req), 32'd1);
    tick();
    reset = 1'b1;
    at_neg();
    check("mr_c2_req_gated", 32'(dmem_req), 32'd0);
    tick();
    reset = 1'b0;
    at_neg();
    check("mr_req",     32'(dmem_req),         32'd0);
    check("mr_stall",   32'(stall_mem),        32'd0);
    check("mr_flags",   32'(flags),            32'd0);
    check("mr_wb_we",   32'(wb_we),            32'd0);
    check("mr_bus_err", 32'(bus_err),          32'd0);
    check("mr_fwd_we",  32'(regwrite_mem),     32'd0);
    check("mr_fwd_dat", 32'(regwrite_dat_mem), 32'd0);

    repeat (3) tick();
    check("wb_queue_drained",  32'(exp_wb.size()),  32'd0);
    check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
